psram_wb_bridge: RTL and testbench
==================================

# psram_wb_bridge

Wishbone B4 classic slave that turns 32-bit bus cycles into single command transactions for the PSRAM serial controller (start/done handshake). It sits directly upstream of that controller. It handles byte-lane to address/size mapping, lane alignment of write and read data, and command and wait-state selection. After reset it runs a one-time initialisation that switches the device into QPI mode.

## Interface
Parameters:
- RD_CMD, 8'hEB, read opcode
- WR_CMD, 8'h38, write opcode
- RD_WAIT, 4'd6, wait states applied to reads
- INIT_CMD, 8'h35, enter-QPI opcode sent after reset
- INIT_EN, 1, 1: send INIT_CMD and then run in QPI; 0: skip init and run in QSPI

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  24  byte address; bits [1:0] ignored
- wb_sel_i  in  4  byte lanes
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  one-cycle acknowledge
- wb_err_o  out  1  one-cycle error
- ctl_start  out  1  one-cycle transaction start
- ctl_done  in  1  controller done
- ctl_addr  out  24  device byte address
- ctl_wdata  out  32  to controller data input; byte 0 is sent first
- ctl_rdata  in  32  from controller data output; byte 0 is received first
- ctl_size  out  3  byte count: 1, 2 or 4
- ctl_cmd  out  8  opcode
- ctl_rd_wr  out  1  1 = read
- ctl_wait_states  out  4  RD_WAIT on reads, 0 otherwise
- ctl_qspi, ctl_qpi  out  1 each  bus mode
- ctl_short_cmd  out  1  command-only transaction

## Operation
- FSM states: INIT, INIT_WAIT, IDLE, BUSY, ACK, GAP.
  - Reset enters INIT if INIT_EN = 1, otherwise IDLE.
- INIT issues a short command:
  - ctl_short_cmd = 1, ctl_cmd = INIT_CMD, ctl_qpi = 0, ctl_qspi = 0.
  - Then INIT_WAIT until ctl_done, then GAP.
  - On leaving INIT_WAIT, the qpi_mode flop sets to 1.
- Mode outputs: ctl_qpi = qpi_mode; ctl_qspi = ~INIT_EN.
- IDLE with wb_cyc_i & wb_stb_i: decode wb_sel_i.
  - 0001 / 0010 / 0100 / 1000 → size 1, offset 0 / 1 / 2 / 3.
  - 0011 → size 2, offset 0; 1100 → size 2, offset 2.
  - 1111 → size 4, offset 0.
  - Any other value, including 0000 → go to ACK with wb_err_o and no device access.
- Request fields (registered in IDLE):
  - ctl_addr = {wb_adr_i[23:2], 2'b00} + offset.
  - ctl_wdata = wb_dat_i >> (8 × offset).
  - ctl_cmd = we ? WR_CMD : RD_CMD; ctl_rd_wr = ~we.
- All ctl_* fields are held stable from ctl_start until the FSM leaves BUSY.
- BUSY: ctl_start is high on the first BUSY cycle only. The FSM waits for ctl_done = 1, then moves to ACK.
- ACK:
  - Reads: wb_dat_o ← ctl_rdata << (8 × offset); unselected lanes are 0.
  - wb_ack_o (or wb_err_o) is high for exactly this cycle, qualified by wb_cyc_i still high.
- GAP: wait until ctl_done = 0, then go to IDLE. No new start is issued while ctl_done is still high.
- wb_cyc_i dropped mid-transaction: the device transaction completes, ack is suppressed, and the FSM proceeds through ACK/GAP normally.
- Reset values:
  - wb_ack_o = wb_err_o = ctl_start = 0; wb_dat_o = 0.
  - ctl_addr = ctl_wdata = 0; ctl_size = 0; ctl_cmd = 0.
  - ctl_rd_wr = 0; ctl_wait_states = 0; ctl_short_cmd = 0; qpi_mode = 0.
- Reset mid-operation aborts immediately; the controller is reset by the same rst.

## Timing
- Request sampled in IDLE at edge N → ctl_start high in cycle N+1.
- ctl_done first high at edge M → ACK in cycle M+1 (wb_ack_o high), GAP from M+2.
- Minimum IDLE-to-ack latency is controller latency + 2 cycles.
- Error path: request at N → wb_err_o in cycle N+1.
- Bus requests arriving during INIT/INIT_WAIT are stalled (no ack) until IDLE.
- wb_ack_o and wb_err_o are never high together; never high two consecutive cycles for one request.
- Back-to-back requests: the second is sampled in IDLE no earlier than one cycle after ctl_done falls.

## Test plan
- Reset with INIT_EN = 1 → one short-command start with ctl_cmd = 8'h35 and ctl_qpi = 0; after done, ctl_qpi = 1 and FSM in IDLE.
- Write adr = 0x000104, sel = 1111, dat = 0xAABBCCDD → ctl_addr = 0x000104, size 4, cmd 0x38, rd_wr = 0, ctl_wdata = 0xAABBCCDD, single ack.
- Read adr = 0x000200, sel = 1100, model returns rdata[15:0] = 0x1234 → ctl_addr = 0x000202, size 2, wait_states = 6, wb_dat_o = 0x12340000.
- Write sel = 0100, dat = 0x00EF0000 → ctl_addr offset +2, size 1, ctl_wdata[7:0] = 0xEF.
- sel = 0101 → wb_err_o for one cycle, no ctl_start issued.
- Controller model holds done for 3 cycles; back-to-back reads → exactly one start per request, none while done is high. Drop wb_cyc_i during BUSY → no ack, FSM returns to IDLE.

Source files
------------

// File: rtl/psram_wb_bridge.sv
// Wishbone B4 classic slave to PSRAM serial controller bridge.
// Each bus cycle becomes one controller transaction (start/done handshake). Byte lanes are
// mapped to a device address and size, write data is shifted down to byte 0, and read data
// is shifted back up into its lanes. After reset an optional one-time short command switches
// the device into QPI mode.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wb_*              Wishbone classic slave (24-bit byte address, 32-bit data, 4 lanes)
//   ctl_start         one-cycle transaction start to the controller
//   ctl_done          controller completion level
//   ctl_addr/size     device byte address and byte count (1, 2 or 4)
//   ctl_wdata/rdata   controller data, byte 0 transferred first
//   ctl_cmd/rd_wr     opcode and direction (1 = read)
//   ctl_wait_states   read wait states, 0 otherwise
//   ctl_qspi/qpi      bus mode
//   ctl_short_cmd     command-only transaction
module psram_wb_bridge #(
    parameter logic [7:0] RD_CMD   = 8'hEB,
    parameter logic [7:0] WR_CMD   = 8'h38,
    parameter logic [3:0] RD_WAIT  = 4'd6,
    parameter logic [7:0] INIT_CMD = 8'h35,
    parameter bit         INIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [23:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        ctl_start,
    input  logic        ctl_done,
    output logic [23:0] ctl_addr,
    output logic [31:0] ctl_wdata,
    input  logic [31:0] ctl_rdata,
    output logic [2:0]  ctl_size,
    output logic [7:0]  ctl_cmd,
    output logic        ctl_rd_wr,
    output logic [3:0]  ctl_wait_states,
    output logic        ctl_qspi,
    output logic        ctl_qpi,
    output logic        ctl_short_cmd
);

    typedef enum logic [2:0] {StInit, StInitWait, StIdle, StBusy, StAck, StGap} state_e;

    state_e state_q, state_d;

    logic        req;
    logic        sel_ok;
    logic [1:0]  sel_off;
    logic [2:0]  sel_size;
    logic        start_d, load_init, load_req;
    logic [31:0] rd_mask, rd_aligned;

    logic        start_q, err_q, aborted_q, qpi_mode_q, rd_wr_q, short_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic [3:0]  wait_q;
    logic [7:0]  cmd_q;
    logic [23:0] addr_q;
    logic [31:0] wdata_q, rdata_q;

    logic unused_adr;
    assign unused_adr = ^wb_adr_i[1:0];

    assign req = wb_cyc_i & wb_stb_i;

    // Lane decode: only naturally aligned 1/2/4-byte patterns reach the device.
    always_comb begin
        sel_ok   = 1'b1;
        sel_off  = 2'd0;
        sel_size = 3'd0;
        case (wb_sel_i)
            4'b0001: begin sel_size = 3'd1; sel_off = 2'd0; end
            4'b0010: begin sel_size = 3'd1; sel_off = 2'd1; end
            4'b0100: begin sel_size = 3'd1; sel_off = 2'd2; end
            4'b1000: begin sel_size = 3'd1; sel_off = 2'd3; end
            4'b0011: begin sel_size = 3'd2; sel_off = 2'd0; end
            4'b1100: begin sel_size = 3'd2; sel_off = 2'd2; end
            4'b1111: begin sel_size = 3'd4; sel_off = 2'd0; end
            default: sel_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT_EN ? StInit : StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:     state_d = StInitWait;
            StInitWait: if (ctl_done) state_d = StGap;
            StIdle:     if (req) state_d = sel_ok ? StBusy : StAck;
            StBusy:     if (ctl_done) state_d = StAck;
            StAck:      state_d = StGap;
            // Hold off the next start until the controller has released done.
            StGap:      if (!ctl_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        start_d   = 1'b0;
        load_init = 1'b0;
        load_req  = 1'b0;
        unique case (state_q)
            StInit: begin
                start_d   = 1'b1;
                load_init = 1'b1;
            end
            StIdle: begin
                start_d  = req & sel_ok;
                load_req = req & sel_ok;
            end
            default: ;
        endcase
        // A cycle abandoned by the master during BUSY still completes on the device side,
        // but must not be acknowledged.
        wb_ack_o = (state_q == StAck) & ~err_q & ~aborted_q & wb_cyc_i;
        wb_err_o = (state_q == StAck) & err_q & ~aborted_q & wb_cyc_i;
    end

    // Read data: keep only the requested bytes, then move them back to their lanes.
    always_comb begin
        rd_mask = 32'hFFFF_FFFF;
        if (size_q == 3'd1) begin
            rd_mask = 32'h0000_00FF;
        end else if (size_q == 3'd2) begin
            rd_mask = 32'h0000_FFFF;
        end
        rd_aligned = (ctl_rdata & rd_mask) << {off_q, 3'b000};
    end

    // Request and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            qpi_mode_q <= 1'b0;
            rd_wr_q    <= 1'b0;
            short_q    <= 1'b0;
            off_q      <= 2'd0;
            size_q     <= 3'd0;
            wait_q     <= 4'd0;
            cmd_q      <= 8'd0;
            addr_q     <= 24'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            start_q <= start_d;
            if (load_init) begin
                short_q <= 1'b1;
                cmd_q   <= INIT_CMD;
                rd_wr_q <= 1'b0;
                wait_q  <= 4'd0;
                size_q  <= 3'd0;
                addr_q  <= 24'd0;
                wdata_q <= 32'd0;
                off_q   <= 2'd0;
            end
            if (load_req) begin
                short_q <= 1'b0;
                cmd_q   <= wb_we_i ? WR_CMD : RD_CMD;
                rd_wr_q <= ~wb_we_i;
                wait_q  <= wb_we_i ? 4'd0 : RD_WAIT;
                size_q  <= sel_size;
                addr_q  <= {wb_adr_i[23:2], sel_off};
                wdata_q <= wb_dat_i >> {sel_off, 3'b000};
                off_q   <= sel_off;
            end
            if (state_q == StIdle && req) begin
                err_q     <= ~sel_ok;
                aborted_q <= 1'b0;
            end
            if (state_q == StBusy && !wb_cyc_i) begin
                aborted_q <= 1'b1;
            end
            if (state_q == StInitWait && ctl_done) begin
                qpi_mode_q <= 1'b1;
            end
            if (state_q == StBusy && ctl_done && rd_wr_q) begin
                rdata_q <= rd_aligned;
            end
        end
    end

    assign wb_dat_o        = rdata_q;
    assign ctl_start       = start_q;
    assign ctl_addr        = addr_q;
    assign ctl_wdata       = wdata_q;
    assign ctl_size        = size_q;
    assign ctl_cmd         = cmd_q;
    assign ctl_rd_wr       = rd_wr_q;
    assign ctl_wait_states = wait_q;
    assign ctl_short_cmd   = short_q;
    assign ctl_qpi         = qpi_mode_q;
    assign ctl_qspi        = ~INIT_EN;

endmodule

// File: tb/tb_psram_wb_bridge.sv
// Scoreboard bench for psram_wb_bridge: directed bus vectors push expected controller
// commands and bus responses; a single negedge monitor pops and compares them.
module tb_psram_wb_bridge;

    localparam logic [7:0] RD_CMD   = 8'hEB;
    localparam logic [7:0] WR_CMD   = 8'h38;
    localparam logic [3:0] RD_WAIT  = 4'd6;
    localparam logic [7:0] INIT_CMD = 8'h35;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [23:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ctl_start, ctl_done;
    logic [23:0] ctl_addr;
    logic [31:0] ctl_wdata, ctl_rdata;
    logic [2:0]  ctl_size;
    logic [7:0]  ctl_cmd;
    logic        ctl_rd_wr;
    logic [3:0]  ctl_wait_states;
    logic        ctl_qspi, ctl_qpi, ctl_short_cmd;

    psram_wb_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_we_i         (wb_we_i),
        .wb_adr_i        (wb_adr_i),
        .wb_sel_i        (wb_sel_i),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_ack_o        (wb_ack_o),
        .wb_err_o        (wb_err_o),
        .ctl_start       (ctl_start),
        .ctl_done        (ctl_done),
        .ctl_addr        (ctl_addr),
        .ctl_wdata       (ctl_wdata),
        .ctl_rdata       (ctl_rdata),
        .ctl_size        (ctl_size),
        .ctl_cmd         (ctl_cmd),
        .ctl_rd_wr       (ctl_rd_wr),
        .ctl_wait_states (ctl_wait_states),
        .ctl_qspi        (ctl_qspi),
        .ctl_qpi         (ctl_qpi),
        .ctl_short_cmd   (ctl_short_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        init;
        logic [23:0] addr;
        logic [2:0]  size;
        logic [7:0]  cmd;
        logic        rd_wr;
        logic [31:0] wdata;
        logic [3:0]  waits;
        logic        qpi;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
    } rsp_t;

    cmd_t        exp_cmd_q[$];
    rsp_t        exp_rsp_q[$];
    logic [31:0] rdata_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   n_start     = 0;
    int   n_exp_start = 0;
    int   timeouts    = 0;
    int   done_hold   = 1;
    logic end_req     = 1'b0;
    logic end_done    = 1'b0;
    logic rst_checked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: done rises two cycles after start and stays high done_hold cycles.
    initial begin
        ctl_done  = 1'b0;
        ctl_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (ctl_start) begin
                repeat (2) begin @(posedge clk); #1; end
                ctl_done  = 1'b1;
                ctl_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
                repeat (done_hold) begin @(posedge clk); #1; end
                ctl_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        rsp_t r;
        cmd_t c;
        if (rst) begin
            if (!rst_checked) begin
                rst_checked = 1'b1;
                chk("rst_ack", 32'(wb_ack_o), 32'(0));
                chk("rst_err", 32'(wb_err_o), 32'(0));
                chk("rst_start", 32'(ctl_start), 32'(0));
                chk("rst_dat_o", wb_dat_o, 32'h0);
                chk("rst_addr", 32'(ctl_addr), 32'(0));
                chk("rst_wdata", ctl_wdata, 32'h0);
                chk("rst_size", 32'(ctl_size), 32'(0));
                chk("rst_cmd", 32'(ctl_cmd), 32'(0));
                chk("rst_rd_wr", 32'(ctl_rd_wr), 32'(0));
                chk("rst_wait", 32'(ctl_wait_states), 32'(0));
                chk("rst_short", 32'(ctl_short_cmd), 32'(0));
                chk("rst_qpi", 32'(ctl_qpi), 32'(0));
            end
        end else begin
            if (wb_ack_o || wb_err_o) begin
                chk("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'(0));
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'({wb_ack_o, wb_err_o}), 32'(0));
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_err", 32'(wb_err_o), 32'(r.err));
                    chk("rsp_ack", 32'(wb_ack_o), 32'(!r.err));
                    if (r.rd && !r.err) chk("rsp_rdata", wb_dat_o, r.data);
                end
            end
            if (ctl_start) begin
                n_start++;
                chk("start_while_done", 32'(ctl_done), 32'(0));
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_start", 32'(ctl_start), 32'(0));
                end else begin
                    c = exp_cmd_q.pop_front();
                    chk("cmd_short", 32'(ctl_short_cmd), 32'(c.init));
                    chk("cmd_opcode", 32'(ctl_cmd), 32'(c.cmd));
                    chk("cmd_qpi", 32'(ctl_qpi), 32'(c.qpi));
                    chk("cmd_qspi", 32'(ctl_qspi), 32'(0));
                    if (!c.init) begin
                        chk("cmd_addr", 32'(ctl_addr), 32'(c.addr));
                        chk("cmd_size", 32'(ctl_size), 32'(c.size));
                        chk("cmd_rd_wr", 32'(ctl_rd_wr), 32'(c.rd_wr));
                        chk("cmd_wdata", ctl_wdata, c.wdata);
                        chk("cmd_wait", 32'(ctl_wait_states), 32'(c.waits));
                    end
                end
            end
            if (end_req && !end_done) begin
                chk("start_count", 32'(n_start), 32'(n_exp_start));
                chk("timeouts", 32'(timeouts), 32'(0));
                chk("rsp_left", 32'(exp_rsp_q.size()), 32'(0));
                chk("cmd_left", 32'(exp_cmd_q.size()), 32'(0));
                end_done = 1'b1;
            end
        end
    end

    task automatic run_vec(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] rdata,
                           input logic exp_err, input logic [23:0] exp_addr,
                           input logic [2:0] exp_size, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdat, input logic drop);
        cmd_t c;
        rsp_t r;
        int   n;
        if (!exp_err) begin
            c.init  = 1'b0;
            c.addr  = exp_addr;
            c.size  = exp_size;
            c.cmd   = we ? WR_CMD : RD_CMD;
            c.rd_wr = !we;
            c.wdata = exp_wdata;
            c.waits = we ? 4'd0 : RD_WAIT;
            c.qpi   = 1'b1;
            exp_cmd_q.push_back(c);
            rdata_q.push_back(rdata);
            n_exp_start++;
        end
        if (!drop) begin
            r.err  = exp_err;
            r.rd   = !we;
            r.data = exp_rdat;
            exp_rsp_q.push_back(r);
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = dat;
        n = 0;
        if (drop) begin
            do begin @(negedge clk); n++; end while (!ctl_start && n < 200);
        end else begin
            do begin @(negedge clk); n++; end while (!(wb_ack_o || wb_err_o) && n < 200);
        end
        if (n >= 200) timeouts++;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        if (drop) repeat (12) @(posedge clk);
    endtask

    initial begin
        cmd_t ci;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 24'h0;
        wb_sel_i = 4'h0;
        wb_dat_i = 32'h0;
        ci.init  = 1'b1;
        ci.addr  = 24'h0;
        ci.size  = 3'd0;
        ci.cmd   = INIT_CMD;
        ci.rd_wr = 1'b0;
        ci.wdata = 32'h0;
        ci.waits = 4'd0;
        ci.qpi   = 1'b0;
        exp_cmd_q.push_back(ci);
        rdata_q.push_back(32'h0);
        n_exp_start++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Issued during init: must stall until IDLE.
        run_vec(1'b1, 24'h000104, 4'b1111, 32'hAABBCCDD, 32'h0, 1'b0,
                24'h000104, 3'd4, 32'hAABBCCDD, 32'h0, 1'b0);
        run_vec(1'b0, 24'h000200, 4'b1100, 32'h0, 32'hDEAD1234, 1'b0,
                24'h000202, 3'd2, 32'h0, 32'h12340000, 1'b0);
        run_vec(1'b1, 24'h000300, 4'b0100, 32'h00EF0000, 32'h0, 1'b0,
                24'h000302, 3'd1, 32'h000000EF, 32'h0, 1'b0);
        run_vec(1'b1, 24'h000310, 4'b0101, 32'h12345678, 32'h0, 1'b1,
                24'h0, 3'd0, 32'h0, 32'h0, 1'b0);
        run_vec(1'b0, 24'h000320, 4'b0000, 32'h0, 32'h0, 1'b1,
                24'h0, 3'd0, 32'h0, 32'h0, 1'b0);
        run_vec(1'b0, 24'h000400, 4'b0010, 32'h0, 32'hFFFFFF5A, 1'b0,
                24'h000401, 3'd1, 32'h0, 32'h00005A00, 1'b0);
        run_vec(1'b0, 24'h000500, 4'b1000, 32'h0, 32'h000000C3, 1'b0,
                24'h000503, 3'd1, 32'h0, 32'hC3000000, 1'b0);
        run_vec(1'b1, 24'h000600, 4'b0011, 32'h11223344, 32'h0, 1'b0,
                24'h000600, 3'd2, 32'h11223344, 32'h0, 1'b0);
        run_vec(1'b0, 24'h000703, 4'b0001, 32'h0, 32'h99887766, 1'b0,
                24'h000700, 3'd1, 32'h0, 32'h00000066, 1'b0);
        run_vec(1'b1, 24'h000900, 4'b1100, 32'hCAFE0000, 32'h0, 1'b0,
                24'h000902, 3'd2, 32'h0000CAFE, 32'h0, 1'b0);

        // Long done pulse with back-to-back reads.
        done_hold = 3;
        run_vec(1'b0, 24'h000800, 4'b1111, 32'h0, 32'h01020304, 1'b0,
                24'h000800, 3'd4, 32'h0, 32'h01020304, 1'b0);
        run_vec(1'b0, 24'h000804, 4'b0011, 32'h0, 32'hAAAA5555, 1'b0,
                24'h000804, 3'd2, 32'h0, 32'h00005555, 1'b0);
        run_vec(1'b0, 24'h000808, 4'b0100, 32'h0, 32'h000000F1, 1'b0,
                24'h00080A, 3'd1, 32'h0, 32'h00F10000, 1'b0);
        done_hold = 1;

        // Master abandons the cycle during BUSY: no ack, then normal service resumes.
        run_vec(1'b0, 24'h000A00, 4'b1111, 32'h0, 32'h55667788, 1'b0,
                24'h000A00, 3'd4, 32'h0, 32'h0, 1'b1);
        run_vec(1'b1, 24'h000B00, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0,
                24'h000B00, 3'd4, 32'h0BADF00D, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        end_req = 1'b1;
        wait (end_done);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
